// File: rtl/sys_mem_responder_pkg.sv
// Shared system-bus encodings used by the responder and the cache controller.
package sys_mem_responder_pkg;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_UNK   = 1'bx;

endpackage

// File: rtl/sys_mem_array.sv
// Single-port synchronous word RAM with byte write enables and a registered read port.
module sys_mem_array #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read register holds its value between read enables.
  always_ff @(posedge clock) begin
    if (!reset) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sys_mem_responder.sv
// System-memory responder: fixed wait-state access to a word RAM, one-cycle SysReady.
// Optional byte write enables: define SYS_MEM_BYTE_EN.
module sys_mem_responder
  import sys_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    SysStrobe,
  input  logic                    SysRW,
  input  logic [31:0]             SysAddr,
  input  logic [DATA_WIDTH-1:0]   SysDataIn,
`ifdef SYS_MEM_BYTE_EN
  input  logic [DATA_WIDTH/8-1:0] SysByteEn,
`endif
  output logic [DATA_WIDTH-1:0]   SysDataOut,
  output logic                    SysReady,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  logic [1:0]            state, next_state;
  logic [CNT_WIDTH-1:0]  count, next_count;
  logic                  capture;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [DATA_WIDTH-1:0] req_data;
  logic [BE_WIDTH-1:0]   req_be;
  logic [ADDR_WIDTH-1:0] sys_idx;
  logic [BE_WIDTH-1:0]   sys_be;
  logic                  launch_rw;
  logic                  mem_re;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  unused_addr_bits;

  assign sys_idx          = SysAddr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{SysAddr[31:ADDR_WIDTH+2], SysAddr[1:0]};

`ifdef SYS_MEM_BYTE_EN
  assign sys_be = SysByteEn;
`else
  assign sys_be = '1;
`endif

  // Next state plus RAM control; the read is launched one cycle early so data lands with SysReady.
  always_comb begin
    next_state = state;
    next_count = count;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (SysStrobe) begin
          capture    = 1'b1;
          next_count = CNT_WIDTH'(WAIT_STATES);
          next_state = (WAIT_STATES == 0) ? ST_RESPOND : ST_BUSY;
        end
      end
      ST_BUSY: begin
        next_count = count - CNT_WIDTH'(1);
        if (count == CNT_WIDTH'(1)) next_state = ST_RESPOND;
      end
      ST_RESPOND: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase

    launch_rw = (state == ST_IDLE) ? SysRW : req_rw;
    mem_addr  = (state == ST_IDLE) ? sys_idx : req_idx;
    mem_re    = (next_state == ST_RESPOND) && (state != ST_RESPOND) && (launch_rw == RW_READ);
    mem_we    = reset && (state == ST_RESPOND) && (req_rw == RW_WRITE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      req_rw   <= RW_READ;
      req_idx  <= '0;
      req_data <= '0;
      req_be   <= '0;
      SysReady <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (capture) begin
        req_rw   <= SysRW;
        req_idx  <= sys_idx;
        req_data <= SysDataIn;
        req_be   <= sys_be;
      end
      SysReady <= (next_state == ST_RESPOND);
      busy     <= (next_state != ST_IDLE);
      if (SysStrobe && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

  sys_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (req_data),
    .be    (req_be),
    .rdata (SysDataOut)
  );

endmodule

// File: tb/tb_sys_mem_responder.sv
// Bench for sys_mem_responder: two instances (3 and 0 wait states) against a schedule-based memory model.
module tb_sys_mem_responder;
  import sys_mem_responder_pkg::*;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned WS0 = 3;
  localparam int unsigned WS1 = 0;

  logic clock = 1'b0;
  logic reset;

  logic          strobe [2];
  logic          rw_s   [2];
  logic [31:0]   addr_s [2];
  logic [DW-1:0] din    [2];
  logic [3:0]    be_s   [2];
  logic [DW-1:0] dout   [2];
  logic          ready  [2];
  logic          busy_o [2];
  logic          ovr    [2];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sys_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS0)) dut_ws3 (
    .clock(clock), .reset(reset), .SysStrobe(strobe[0]), .SysRW(rw_s[0]),
    .SysAddr(addr_s[0]), .SysDataIn(din[0]),
`ifdef SYS_MEM_BYTE_EN
    .SysByteEn(be_s[0]),
`endif
    .SysDataOut(dout[0]), .SysReady(ready[0]), .busy(busy_o[0]), .overrun(ovr[0])
  );

  sys_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS1)) dut_ws0 (
    .clock(clock), .reset(reset), .SysStrobe(strobe[1]), .SysRW(rw_s[1]),
    .SysAddr(addr_s[1]), .SysDataIn(din[1]),
`ifdef SYS_MEM_BYTE_EN
    .SysByteEn(be_s[1]),
`endif
    .SysDataOut(dout[1]), .SysReady(ready[1]), .busy(busy_o[1]), .overrun(ovr[1])
  );

  function automatic int ws(input int i);
    return (i == 0) ? int'(WS0) : int'(WS1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: each accepted request owns a response edge; writes land one edge later.
  bit [31:0] mmem [2][1024];
  bit        model_on = 1'b0;
  longint    ecount = 0;
  bit        pend  [2];
  longint    r_edge [2];
  bit        p_rw  [2];
  int        p_idx [2];
  bit [31:0] p_data [2];
  bit [3:0]  p_be  [2];
  bit        e_ready [2];
  bit [31:0] e_data  [2];
  bit        e_busy  [2];
  bit        e_ovr   [2];

  always @(posedge clock) begin
    bit was_busy;
    ecount++;
    if (!reset) begin
      model_on = 1'b1;
      for (int i = 0; i < 2; i++) begin
        pend[i] = 0; e_ready[i] = 0; e_data[i] = 0; e_busy[i] = 0; e_ovr[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        was_busy = pend[i];
        if (pend[i] && ecount == r_edge[i] + 1) begin
          if (p_rw[i] == RW_WRITE)
            for (int b = 0; b < 4; b++)
              if (p_be[i][b]) mmem[i][p_idx[i]][b*8 +: 8] = p_data[i][b*8 +: 8];
          pend[i] = 0;
        end
        if (strobe[i]) begin
          if (was_busy) e_ovr[i] = 1;
          else begin
            pend[i]   = 1;
            r_edge[i] = ecount + longint'(ws(i));
            p_rw[i]   = rw_s[i];
            p_idx[i]  = int'(addr_s[i][AW+1:2]);
            p_data[i] = din[i];
`ifdef SYS_MEM_BYTE_EN
            p_be[i]   = be_s[i];
`else
            p_be[i]   = 4'hF;
`endif
          end
        end
        e_ready[i] = pend[i] && (ecount == r_edge[i]);
        if (e_ready[i] && p_rw[i] == RW_READ) e_data[i] = mmem[i][p_idx[i]];
        e_busy[i] = pend[i];
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d ready", i),   32'(ready[i]),  32'(e_ready[i]));
        check($sformatf("dut%0d busy", i),    32'(busy_o[i]), 32'(e_busy[i]));
        check($sformatf("dut%0d overrun", i), 32'(ovr[i]),    32'(e_ovr[i]));
        check($sformatf("dut%0d data", i),    dout[i],        e_data[i]);
      end
    end
  end

  task automatic wait_ready(input int i, output int lat);
    lat = 1;
    while (!ready[i] && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic req(input int i, input logic rw, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    int lat;
    @(negedge clock);
    strobe[i] = 1'b1; rw_s[i] = rw; addr_s[i] = a; din[i] = d; be_s[i] = be;
    @(negedge clock);
    strobe[i] = 1'b0;
    wait_ready(i, lat);
    check($sformatf("dut%0d latency", i), 32'(lat), 32'(ws(i) + 1));
  endtask

  logic [31:0] pool [8] = '{32'h10, 32'h20, 32'h30, 32'h04, 32'h44, 32'h80, 32'hFC, 32'hFFC};

  initial begin
    int lat;
    int n;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      strobe[i] = 0; rw_s[i] = RW_READ; addr_s[i] = '0; din[i] = '0; be_s[i] = 4'hF;
    end
    repeat (3) @(negedge clock);
    check("reset ready", 32'(ready[0]), 32'd0);
    check("reset busy", 32'(busy_o[0]), 32'd0);
    check("reset data", dout[0], 32'd0);
    reset = 1'b1;

    // Basic write then read, 3 wait states.
    req(0, RW_WRITE, 32'h0000_0010, 32'hDEADBEEF, 4'hF);
    req(0, RW_READ,  32'h0000_0010, 32'h0, 4'hF);
    check("read 0x10", dout[0], 32'hDEADBEEF);

    // Address aliasing above the word-index bits.
    req(0, RW_WRITE, 32'h0000_1004, 32'h5A5A5A5A, 4'hF);
    req(0, RW_READ,  32'h0000_0004, 32'h0, 4'hF);
    check("alias read 0x4", dout[0], 32'h5A5A5A5A);
    check("write keeps data", dout[0], 32'h5A5A5A5A);

    // Zero wait states, requests every 2 cycles.
    req(1, RW_WRITE, 32'h0000_0040, 32'h01020304, 4'hF);
    req(1, RW_WRITE, 32'h0000_0044, 32'hA0B0C0D0, 4'hF);
    req(1, RW_READ,  32'h0000_0040, 32'h0, 4'hF);
    check("ws0 read 0x40", dout[1], 32'h01020304);
    req(1, RW_READ,  32'h0000_0044, 32'h0, 4'hF);
    check("ws0 read 0x44", dout[1], 32'hA0B0C0D0);

    req(0, RW_WRITE, 32'h0000_0020, 32'hCAFE0001, 4'hF);

    // Strobe during the second busy cycle is dropped and flags overrun.
    @(negedge clock);
    strobe[0] = 1; rw_s[0] = RW_READ; addr_s[0] = 32'h10;
    @(negedge clock); strobe[0] = 0;
    @(negedge clock); strobe[0] = 1; rw_s[0] = RW_WRITE; din[0] = 32'h0;
    @(negedge clock); strobe[0] = 0;
    wait_ready(0, lat);
    check("overrun read 0x10", dout[0], 32'hDEADBEEF);
    check("overrun set", 32'(ovr[0]), 32'd1);
    req(0, RW_READ, 32'h0000_0010, 32'h0, 4'hF);
    check("dropped write absent", dout[0], 32'hDEADBEEF);
    check("overrun sticky", 32'(ovr[0]), 32'd1);

    // Reset mid-write abandons the transaction.
    @(negedge clock);
    strobe[0] = 1; rw_s[0] = RW_WRITE; addr_s[0] = 32'h20; din[0] = 32'h12345678;
    @(negedge clock); strobe[0] = 0; reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clock);
      if (ready[0]) n++;
    end
    check("aborted ready count", 32'(n), 32'd0);
    check("overrun cleared", 32'(ovr[0]), 32'd0);
    req(0, RW_READ, 32'h0000_0020, 32'h0, 4'hF);
    check("read 0x20 after abort", dout[0], 32'hCAFE0001);

`ifdef SYS_MEM_BYTE_EN
    req(0, RW_WRITE, 32'h0000_0030, 32'h11223344, 4'hF);
    req(0, RW_WRITE, 32'h0000_0030, 32'hAABBCCDD, 4'b0101);
    req(0, RW_READ,  32'h0000_0030, 32'h0, 4'hF);
    check("byte enable merge", dout[0], 32'h11BB33DD);
    req(0, RW_WRITE, 32'h0000_0030, 32'hFFFFFFFF, 4'b0000);
    req(0, RW_READ,  32'h0000_0030, 32'h0, 4'hF);
    check("zero enables", dout[0], 32'h11BB33DD);
`endif

    // Initialise the random address pool on both instances.
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++) req(i, RW_WRITE, pool[k], $urandom, 4'hF);

    // Well-spaced random transactions.
    for (int t = 0; t < 80; t++) begin
      int i;
      i = int'($urandom_range(0, 1));
      req(i, logic'($urandom_range(0, 1)),
          ($urandom & 32'hFFFF_F000) | pool[$urandom_range(0, 7)] | ($urandom & 32'h3),
          $urandom, 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Unpaced random strobes, including overruns.
    for (int t = 0; t < 300; t++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        strobe[i] = ($urandom_range(0, 3) == 0);
        rw_s[i]   = logic'($urandom_range(0, 1));
        addr_s[i] = ($urandom & 32'hFFFF_F000) | pool[$urandom_range(0, 7)];
        din[i]    = $urandom;
        be_s[i]   = 4'($urandom);
      end
    end
    @(negedge clock);
    strobe[0] = 0; strobe[1] = 0;
    repeat (8) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sys_mem_responder.md
# sys_mem_responder

System-memory responder on the far side of the cache controller's system bus. Accepts a one-cycle `SysStrobe` request (read or write) carrying address and write data, waits a fixed, configurable number of wait states, performs the access on an internal word-addressed memory array, and answers with a one-cycle `SysReady` pulse, returning read data on `SysDataOut`. Serves as the backing store behind the data cache and as the memory model for cache-level verification.

## Interface
- `ADDR_WIDTH`, 10: word-index width; array holds 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width; must be a multiple of 8.
- `WAIT_STATES`, 3: cycles spent in BUSY before the response; 0 allowed.
- `clock`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-low; sampled only on posedge `clock`.
- `SysStrobe`  in  1: one-cycle request pulse.
- `SysRW`  in  1: `RW_READ` / `RW_WRITE`, valid with `SysStrobe`.
- `SysAddr`  in  32: byte address; word index = `SysAddr[ADDR_WIDTH+1:2]`, other bits ignored.
- `SysDataIn`  in  DATA_WIDTH: write data, valid with `SysStrobe`.
- `SysByteEn`  in  DATA_WIDTH/8: byte write enables (present only with `SYS_MEM_BYTE_EN`).
- `SysDataOut`  out  DATA_WIDTH: read data.
- `SysReady`  out  1: one-cycle completion pulse, reads and writes.
- `busy`  out  1: high in BUSY and RESPOND.
- `overrun`  out  1: sticky; a strobe arrived while not IDLE.

## Operation
- FSM states: IDLE, BUSY, RESPOND.
- IDLE: on `SysStrobe`, capture `SysRW`, word index, `SysDataIn` (and `SysByteEn`) into request registers, load wait counter with `WAIT_STATES`; go to BUSY, or directly to RESPOND if `WAIT_STATES`==0.
- BUSY: decrement counter each cycle; at counter==1 (carry) go to RESPOND.
- RESPOND: `SysReady`=1 for exactly this cycle; write: commit captured data to array at captured index; read: `SysDataOut` driven with array word at captured index; next state IDLE.
- `SysDataOut` holds last read value until next read response; writes leave it unchanged.
- Strobe outside IDLE: ignored (no capture, no queueing), `overrun` set to 1 and held until reset.
- Index wraps/aliases: upper address bits above `ADDR_WIDTH+1` and low 2 bits ignored.
- Counter width `$clog2(WAIT_STATES+1)`, minimum 1 bit.
- Array contents are not reset; reads of never-written words return X in simulation.

## Timing
- Reset (`reset`==0 at posedge): state IDLE, `SysReady`=0, `SysDataOut`=0, `busy`=0, `overrun`=0, counter 0, request registers 0. Reset mid-transaction abandons it: no write commits, no `SysReady`.
- Strobe sampled at edge ending cycle T → `SysReady` high in cycle T+WAIT_STATES+1 (T+1 for 0 wait states).
- Read data valid on `SysDataOut` in the same cycle as `SysReady`.
- Write visible to a read strobed in the cycle after `SysReady` or later.
- Minimum request spacing: WAIT_STATES+2 cycles; a strobe coincident with `SysReady` is an overrun.

## Configuration
- `SYS_MEM_BYTE_EN` defined: `SysByteEn` port exists; write updates only bytes with enable=1; all-zero enables → no array change, `SysReady` still pulses.
- Undefined: no `SysByteEn` port; every write replaces the full word.

## Structure
- Shared defines file: `RW_READ`, `RW_WRITE`, `RW_UNK` (same encodings used by the cache controller); responder state encodings live locally.
- One sub-module: `sys_mem_array`, single-port synchronous RAM (write enable, optional byte enables, registered read), instantiated once.

## Test plan
- Reset, write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 → `SysReady` at T+4 for each (WAIT_STATES=3), read `SysDataOut`=0xDEADBEEF.
- WAIT_STATES=0: read strobe in T → `SysReady` in T+1; back-to-back requests every 2 cycles all complete.
- Strobe again in the second BUSY cycle → ignored, `overrun`=1 and stays 1, original request completes normally.
- Reset low during BUSY of a write to 0x20 → no `SysReady`; later read of 0x20 returns prior contents.
- `SYS_MEM_BYTE_EN`: word 0x11223344, write 0xAABBCCDD with enables 4'b0101 → read 0x11BB33DD.
- Address alias: write 0x5A5A5A5A to 0x0000_1004 (ADDR_WIDTH=10), read 0x0000_0004 → 0x5A5A5A5A.
